// File: rtl/pres_dc.sv
// Presettable down counter used as a load-and-expire interval timer.
// Load captures p, counting ends with a one-cycle tc pulse, then stops (one-shot) or reloads (periodic).
//
// state | meaning
// IDLE  | expired, reset or loaded with zero; q holds and en is ignored
// COUNT | q decrements on each enabled clock until the terminal step at q=1
module pres_dc #(
  parameter int reg_size = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [reg_size-1:0] p,
  input  logic                load,
  input  logic                en,
  input  logic                reload,
  output logic [reg_size-1:0] q,
  output logic                tc,
  output logic                busy
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [reg_size-1:0] ZERO = '0;
  localparam logic [reg_size-1:0] ONE  = {{(reg_size-1){1'b0}}, 1'b1};

  state_t              state;
  logic [reg_size-1:0] r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= ZERO;
      r     <= ZERO;
      state <= IDLE;
      tc    <= 1'b0;
      busy  <= 1'b0;
    end else if (load) begin
      q  <= p;
      r  <= p;
      tc <= 1'b0;
      if (p != ZERO) begin
        state <= COUNT;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          tc   <= 1'b0;
          busy <= 1'b0;
        end
        COUNT: begin
          if (!en) begin
            tc <= 1'b0;
          end else if (q == ONE) begin
            // Terminal step: reload mode is sampled only here.
            tc <= 1'b1;
            if (reload) begin
              q    <= r;
              busy <= 1'b1;
            end else begin
              q     <= ZERO;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            q  <= q - ONE;
            tc <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tc    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pres_dc.sv
// Directed bench for pres_dc (reg_size=4) with hand-computed expected values.
module tb_pres_dc;

  logic       clk;
  logic       rst;
  logic [3:0] p;
  logic       load;
  logic       en;
  logic       reload;
  logic [3:0] q;
  logic       tc;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  pres_dc #(.reg_size(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .p      (p),
    .load   (load),
    .en     (en),
    .reload (reload),
    .q      (q),
    .tc     (tc),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int eq, input int etc, input int ebusy);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".tc"}, 32'(tc), 32'(etc));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
  endtask

  // Expected q/tc after each edge of the periodic-with-gaps sequence (after the load edge).
  int gap_en [5] = '{1, 1, 0, 1, 1};
  int gap_q  [5] = '{3, 2, 2, 1, 4};
  int gap_tc [5] = '{0, 0, 0, 0, 1};

  initial begin
    int tc_count;
    int zero_seen;
    int tc_at [2];

    rst = 1'b0; p = '0; load = 1'b0; en = 1'b0; reload = 1'b0;
    #2 rst = 1'b1;
    step();
    step();
    chk_out("reset", 0, 0, 0);
    rst = 1'b0;

    // One-shot from 3
    p = 4'd3; load = 1'b1; reload = 1'b0; en = 1'b1;
    step();
    chk_out("os_load", 3, 0, 1);
    load = 1'b0; p = 4'd0;
    step();
    chk_out("os_2", 2, 0, 1);
    step();
    chk_out("os_1", 1, 0, 1);
    step();
    chk_out("os_expire", 0, 1, 0);
    step();
    chk_out("os_after", 0, 0, 0);
    step();
    chk_out("os_after2", 0, 0, 0);

    // Periodic from 4 with an enable gap
    p = 4'd4; load = 1'b1; reload = 1'b1;
    step();
    chk_out("per_load", 4, 0, 1);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = gap_en[i][0];
      step();
      chk_out($sformatf("per_gap%0d", i), gap_q[i], gap_tc[i], 1);
    end

    // Load on the terminal edge wins
    en = 1'b1;
    step();
    chk_out("col_3", 3, 0, 1);
    step();
    step();
    chk_out("col_1", 1, 0, 1);
    p = 4'd9; load = 1'b1;
    step();
    chk_out("col_load9", 9, 0, 1);
    p = 4'd0;
    step();
    chk_out("col_load0", 0, 0, 0);
    load = 1'b0;
    step();
    chk_out("col_idle", 0, 0, 0);

    // Max value periodic for 30 enabled edges
    p = 4'd15; load = 1'b1; reload = 1'b1;
    step();
    chk_out("max_load", 15, 0, 1);
    load = 1'b0;
    tc_count = 0; zero_seen = 0; tc_at[0] = 0; tc_at[1] = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (tc) begin
        if (tc_count < 2) tc_at[tc_count] = i;
        tc_count++;
      end
      if (q == 4'd0) zero_seen++;
    end
    chk("max_tc_count", 32'(tc_count), 32'd2);
    chk("max_tc_first", 32'(tc_at[0]), 32'd15);
    chk("max_tc_gap", 32'(tc_at[1] - tc_at[0]), 32'd15);
    chk("max_no_zero", 32'(zero_seen), 32'd0);

    // p changes without load are ignored
    p = 4'd7; load = 1'b1;
    step();
    chk_out("pchg_load", 7, 0, 1);
    load = 1'b0; p = 4'd2;
    step(); step(); step();
    chk_out("pchg_4", 4, 0, 1);
    step(); step(); step();
    chk_out("pchg_1", 1, 0, 1);
    step();
    chk_out("pchg_reload", 7, 1, 1);

    // Async reset mid-count
    p = 4'd5; load = 1'b1;
    step();
    chk_out("rst_pre", 5, 0, 1);
    load = 1'b0; en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk_out("rst_async", 0, 0, 0);
    step();
    rst = 1'b0; en = 1'b1;
    step(); step();
    chk_out("rst_hold", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pres_dc.md
# pres_dc

Synchronous presettable down counter (the count-down counterpart of the presettable up counter), used as a load-and-expire interval timer. A parallel value on `p` is captured by `load`. The counter then decrements once per enabled clock and flags expiry with a one-cycle terminal-count pulse. It can stop at zero (one-shot) or reload the captured preset (periodic), which makes it the divider/timeout element alongside the ripple up counters in the counter library.

## Interface
- `reg_size`, default 4: counter and preset width in bits; legal values ≥ 2.

- `clk`  in  1  rising-edge clock; all state changes on this edge.
- `rst`  in  1  asynchronous, active-high reset.
- `p`  in  reg_size  preset value, sampled only when `load`=1.
- `load`  in  1  synchronous parallel load; highest priority after `rst`.
- `en`  in  1  count enable; counter holds when 0.
- `reload`  in  1  mode select: 1 = periodic auto-reload, 0 = one-shot; sampled at the terminal step.
- `q`  out  reg_size  current count (registered).
- `tc`  out  1  terminal-count pulse (registered), high for exactly one cycle per expiry.
- `busy`  out  1  high while in COUNT state (registered).

## Operation
- Internal state:
  - 2-state FSM: IDLE, COUNT.
  - Reload register `r[reg_size-1:0]` holds the last loaded preset.
- Reset (`rst`=1, asynchronous): `q`=0, `r`=0, state=IDLE, `tc`=0, `busy`=0. Outputs stay at these values for as long as `rst` is high.
- Priority at each edge: `rst` > `load` > counting > hold.
- Load (`load`=1, any state):
  - `q`<=`p` and `r`<=`p`; `tc`<=0.
  - If `p`≠0, go to COUNT. If `p`=0, go to IDLE.
  - `en` and `reload` are ignored on a load cycle.
- IDLE, `load`=0: `q` holds; `en` is ignored; `tc`<=0.
- COUNT, `load`=0, `en`=0: `q` holds; `tc`<=0; state is unchanged.
- COUNT, `load`=0, `en`=1:
  - `q`>1: `q`<=`q`-1; `tc`<=0.
  - `q`=1 (terminal step): `tc`<=1.
    - If `reload`=1: `q`<=`r` and stay in COUNT.
    - If `reload`=0: `q`<=0 and go to IDLE.
- `busy` is the registered copy of (next state == COUNT), so it updates on the same edge as the state.
- Arithmetic: the decrement is modulo 2^reg_size. The counter never underflows because the terminal step is taken at `q`=1 and COUNT is never entered with `q`=0.
- `r` changes only on `load` or `rst`. Changing `p` without `load` has no effect.
- Load coinciding with the terminal step: the load wins. `tc` stays 0 and counting restarts from the new `p`.

## Timing
- Load-to-output latency: 1 edge. `q`=`p` is visible after the load edge.
- One-shot period: after loading N (N≥1) with `en` held high, `tc` is high during the cycle following the N-th enabled edge. On that same edge `q` becomes 0 and `busy` falls.
- Periodic mode: with `en` held high, `tc` pulses once every N cycles. `q` sequence: N, N-1, …, 1, N, …
- `en` gaps stretch the period. The count stays frozen and `tc` is never held across a gap.
- `tc` is never high for two consecutive cycles except in periodic mode with N=1, where it stays high continuously while `en`=1.
- `reload` change mid-count: takes effect at the next terminal step only.
- `rst` asserted mid-count: outputs go to reset values immediately, without waiting for a clock edge. After release, the counter stays IDLE until the next `load`.
- `load` with `p`=0: `q`=0, `busy`=0, no `tc` pulse.

## Test plan
- Reset: drive `rst`=1 asynchronously mid-cycle during COUNT with `q`=5 -> `q`=0, `tc`=0, `busy`=0 before the next edge. Hold after release until `load`.
- One-shot, reg_size=4: load `p`=3, `reload`=0, `en`=1 -> `q`=3,2,1,0 on successive edges. `tc`=1 only in the cycle `q` first reads 0; `busy` falls on the same edge. Further `en` has no effect.
- Periodic with gaps: load `p`=4, `reload`=1, `en` toggling 1,1,0,1,1 -> `q`=4,3,2,2,1,4. One `tc` pulse, coincident with `q` returning to 4. `busy` stays 1 throughout.
- Load collisions: `load` `p`=9 on the terminal edge (`q`=1, `en`=1) -> `q`=9, `tc`=0. Then `load` `p`=0 -> `q`=0, `busy`=0, no `tc`.
- Max value, reg_size=4: load `p`=15, `reload`=1, `en`=1 for 30 cycles -> exactly 2 `tc` pulses, 15 cycles apart. `q` never shows 0.
- `p` change without `load`: while counting from 7, change `p` to 2 -> the count continues unaffected. The next reload restores 7.
